// File: rtl/ivs_cfg_seq.sv
// AHB-lite write sequencer: optional soft reset, NUM_PAR fetched parameter words, then the control word.
// One transfer outstanding at a time; address and data phases stall on hready, fetches stall on par_vld.
module ivs_cfg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_PAR   = 8
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        start,
  input  logic        soft_rst_en,
  input  logic [31:0] ctrl_word,
  output logic        par_req,
  output logic [2:0]  par_idx,
  input  logic        par_vld,
  input  logic [31:0] par_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic [1:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hready_in,
  input  logic        hready,
  input  logic [1:0]  hresp
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ADDR, S_DATA, S_FIN} state_t;
  typedef enum logic [1:0] {W_SRST, W_PAR, W_CTRL} wkind_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] LAST_IDX      = 3'(NUM_PAR - 1);

  state_t      state, state_nxt;
  wkind_t      kind, kind_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [31:0] ctrl_q;
  logic [31:0] wr_dat, wr_dat_nxt;
  logic [31:0] addr_nxt;
  logic        start_acc;
  logic        err_set;

  assign hsize     = 2'b10;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hready_in = hready;

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    kind_nxt   = kind;
    idx_nxt    = idx;
    wr_dat_nxt = wr_dat;
    addr_nxt   = haddr;
    start_acc  = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (soft_rst_en) begin
            state_nxt  = S_ADDR;
            kind_nxt   = W_SRST;
            wr_dat_nxt = 32'h0000_0001;
            addr_nxt   = BASE_ADDR + 32'h004;
          end else begin
            state_nxt = S_FETCH;
            kind_nxt  = W_PAR;
            idx_nxt   = 3'd0;
          end
        end
      end
      S_FETCH: begin
        if (par_req && par_vld) begin
          state_nxt  = S_ADDR;
          wr_dat_nxt = par_data;
          addr_nxt   = BASE_ADDR + 32'h100 + {27'd0, idx, 2'b00};
        end
      end
      S_ADDR: begin
        if (hready) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (hready) begin
          if (hresp == HRESP_ERROR) begin
            state_nxt = S_FIN;
            err_set   = 1'b1;
          end else begin
            unique case (kind)
              W_SRST: begin
                state_nxt = S_FETCH;
                kind_nxt  = W_PAR;
                idx_nxt   = 3'd0;
              end
              W_PAR: begin
                if (idx == LAST_IDX) begin
                  state_nxt  = S_ADDR;
                  kind_nxt   = W_CTRL;
                  wr_dat_nxt = ctrl_q;
                  addr_nxt   = BASE_ADDR;
                end else begin
                  state_nxt = S_FETCH;
                  idx_nxt   = idx + 3'd1;
                end
              end
              default: state_nxt = S_FIN;
            endcase
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequence bookkeeping: which write is in flight and its data.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      kind   <= W_SRST;
      idx    <= 3'd0;
      wr_dat <= 32'd0;
      ctrl_q <= 32'd0;
    end else begin
      kind   <= kind_nxt;
      idx    <= idx_nxt;
      wr_dat <= wr_dat_nxt;
      if (start_acc) begin
        ctrl_q <= ctrl_word;
      end
    end
  end

  // Every output is decoded from the next state so it lines up with the state it belongs to.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      hsel    <= 1'b0;
      htrans  <= HTRANS_IDLE;
      hwrite  <= 1'b0;
      haddr   <= BASE_ADDR;
      hwdata  <= 32'd0;
      par_req <= 1'b0;
      par_idx <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      hsel    <= (state_nxt == S_ADDR);
      htrans  <= (state_nxt == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      hwrite  <= (state_nxt == S_ADDR);
      haddr   <= addr_nxt;
      if ((state_nxt == S_DATA) && (state != S_DATA)) begin
        hwdata <= wr_dat;
      end
      par_req <= (state_nxt == S_FETCH);
      par_idx <= idx_nxt;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_FIN);
      if (start_acc) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ivs_cfg_seq.sv
// Directed bench for ivs_cfg_seq: behavioural one-wait AHB slave, parameter source, write scoreboard.
module tb_ivs_cfg_seq;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          NP   = 8;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        start, soft_rst_en;
  logic [31:0] ctrl_word;
  logic        par_req;
  logic [2:0]  par_idx;
  logic        par_vld;
  logic [31:0] par_data;
  logic        busy, done, err;
  logic        hsel, hwrite, hready_in;
  logic [1:0]  htrans, hsize;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [1:0]  hresp;

  ivs_cfg_seq #(.BASE_ADDR(BASE), .NUM_PAR(NP)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .start(start), .soft_rst_en(soft_rst_en),
    .ctrl_word(ctrl_word), .par_req(par_req), .par_idx(par_idx), .par_vld(par_vld),
    .par_data(par_data), .busy(busy), .done(done), .err(err), .hsel(hsel),
    .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hready_in(hready_in), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] par_val[NP];
  int          par_dly[NP];
  bit          tie_hi = 0;
  bit          rnd_mode = 0;
  bit          err_mode = 0;
  logic [31:0] err_addr = 32'h0;

  bit          dp_act = 0;
  bit          dp_err = 0;
  logic [31:0] dp_addr = 32'h0;
  int          nonseq_cnt = 0;
  int          srst_cnt = 0;
  int          srst_at_par = -1;
  logic [31:0] cfg_par[NP];
  logic [31:0] glb_ctrl = 32'h0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Behavioural slave: one wait state per transfer, optional random extra waits and an ERROR address.
  initial begin : slave
    logic        nr;
    logic [1:0]  nresp;
    bit          acc;
    bit          a_vld, d_vld;
    logic [31:0] a_hold, d_hold;
    logic [63:0] e;
    a_vld = 0; d_vld = 0; a_hold = 0; d_hold = 0;
    hready = 1'b1;
    hresp  = 2'b00;
    forever begin
      @(negedge hclk);
      acc = 0;
      nr = 1'b1;
      nresp = 2'b00;
      if (!hrst_n) begin
        dp_act = 0; a_vld = 0; d_vld = 0;
      end else begin
        if (par_req) check("htrans_idle_in_fetch", 32'(htrans), 32'd0);
        if (dp_act) begin
          check("no_nonseq_in_data", 32'(htrans), 32'd0);
          if (d_vld) check("hwdata_stable", hwdata, d_hold);
          d_hold = hwdata; d_vld = 1;
          if (hready) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("wr_addr", dp_addr, e[63:32]);
              check("wr_data", hwdata, e[31:0]);
            end
            if (dp_addr == BASE + 32'h004 && hwdata[0]) srst_cnt++;
            if (dp_addr == BASE + 32'h100) srst_at_par = srst_cnt;
            if (dp_addr >= BASE + 32'h100 && dp_addr < BASE + 32'h120)
              cfg_par[(dp_addr - BASE - 32'h100) >> 2] = hwdata;
            if (dp_addr == BASE) glb_ctrl = hwdata;
            dp_act = 0; d_vld = 0;
          end
        end
        if (hsel && htrans == 2'b10 && hwrite) begin
          if (a_vld) check("haddr_stable", haddr, a_hold);
          if (hready) begin
            acc = 1; dp_act = 1; dp_addr = haddr; a_vld = 0;
            dp_err = err_mode && (haddr == err_addr);
            nonseq_cnt++;
          end else begin
            a_hold = haddr; a_vld = 1;
          end
        end else begin
          a_vld = 0;
        end
        if (acc) begin
          nr = 1'b0;
          nresp = dp_err ? 2'b01 : 2'b00;
        end else begin
          nr = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
          nresp = (dp_act && dp_err) ? 2'b01 : 2'b00;
        end
      end
      @(posedge hclk);
      #1;
      hready = nr;
      hresp  = nresp;
    end
  end

  // Parameter source: answers par_req after par_dly[idx] cycles; junk data whenever unrequested.
  initial begin : par_src
    int cnt;
    bit loaded;
    cnt = 0; loaded = 0;
    par_vld = 1'b0; par_data = 32'h0;
    forever begin
      @(negedge hclk);
      if (!par_req) begin
        loaded = 0; par_vld = tie_hi; par_data = 32'hDEAD_BEEF;
      end else begin
        if (!loaded) begin cnt = par_dly[par_idx]; loaded = 1; end
        if (cnt == 0) begin
          par_vld = 1'b1; par_data = par_val[par_idx];
        end else begin
          cnt--; par_vld = 1'b0; par_data = 32'hDEAD_BEEF;
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge hclk);
      if (done) done_cnt++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic push_seq(input bit srst, input logic [31:0] cw, input int npar, input bit with_ctrl);
    if (srst) exp_q.push_back({BASE + 32'h004, 32'h1});
    for (int i = 0; i < npar; i++) exp_q.push_back({BASE + 32'h100 + 32'(4 * i), par_val[i]});
    if (with_ctrl) exp_q.push_back({BASE, cw});
  endtask

  task automatic run_start(input bit srst, input logic [31:0] cw);
    soft_rst_en = srst; ctrl_word = cw; start = 1'b1;
    @(negedge hclk);
    start = 1'b0; soft_rst_en = 1'b0; ctrl_word = ~cw;
    check("busy_at_t1", 32'(busy), 32'd1);
    check("err_cleared_by_start", 32'(err), 32'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) cyc++;
      if (done) break;
      @(negedge hclk);
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic end_seq(input string tag, input int done_base, input logic exp_err);
    repeat (4) @(negedge hclk);
    check({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_htrans"}, 32'(htrans), 32'd0);
    check({tag, "_hsel"}, 32'(hsel), 32'd0);
    check({tag, "_hwrite"}, 32'(hwrite), 32'd0);
    check({tag, "_haddr"}, haddr, BASE);
    check({tag, "_hwdata"}, hwdata, 32'd0);
    check({tag, "_par_req"}, 32'(par_req), 32'd0);
    check({tag, "_par_idx"}, 32'(par_idx), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin : main
    int cyc, base, ns0;
    hrst_n = 1'b0; start = 1'b0; soft_rst_en = 1'b0; ctrl_word = 32'h0;
    for (int i = 0; i < NP; i++) begin par_dly[i] = 0; cfg_par[i] = 32'h0; end
    repeat (3) @(negedge hclk);
    check_reset_vals("rst");
    check("hsize", 32'(hsize), 32'd2);
    check("hburst", 32'(hburst), 32'd0);
    check("hprot", 32'(hprot), 32'd3);
    hrst_n = 1'b1;
    repeat (2) @(negedge hclk);

    // A: plain sequence, pars 0x11*i
    for (int i = 0; i < NP; i++) par_val[i] = 32'(32'h11 * i);
    base = done_cnt;
    push_seq(0, 32'hA5A5_0001, NP, 1);
    run_start(0, 32'hA5A5_0001);
    wait_done(cyc);
    end_seq("A", base, 1'b0);
    check("A_cfg_par3", cfg_par[3], 32'h33);
    check("A_glb_ctrl", glb_ctrl, 32'hA5A5_0001);

    // B: soft reset first, par_vld tied high, exact length, start during done ignored
    tie_hi = 1; srst_cnt = 0; srst_at_par = -1;
    for (int i = 0; i < NP; i++) par_val[i] = 32'hB000_0000 + 32'(i * 7);
    base = done_cnt;
    push_seq(1, 32'h0000_00C3, NP, 1);
    run_start(1, 32'h0000_00C3);
    wait_done(cyc);
    check("B_busy_cycles", 32'(cyc), 32'd39);
    start = 1'b1;
    @(negedge hclk);
    start = 1'b0;
    check("B_start_at_done_ignored", 32'(busy), 32'd0);
    check("B_done_one_cycle", 32'(done), 32'd0);
    end_seq("B", base, 1'b0);
    check("B_srst_pulses", 32'(srst_cnt), 32'd1);
    check("B_srst_before_par", 32'(srst_at_par), 32'd1);
    check("B_glb_ctrl", glb_ctrl, 32'h0000_00C3);
    tie_hi = 0;

    // C: delayed par_vld 0/5/17 per word
    for (int i = 0; i < NP; i++) begin
      par_val[i] = 32'hC0DE_0000 | 32'(i);
      par_dly[i] = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 5 : 17);
    end
    base = done_cnt;
    push_seq(0, 32'h1234_5678, NP, 1);
    run_start(0, 32'h1234_5678);
    wait_done(cyc);
    end_seq("C", base, 1'b0);
    for (int i = 0; i < NP; i++) par_dly[i] = 0;

    // D: random hready stalls in address and data phases
    rnd_mode = 1;
    for (int i = 0; i < NP; i++) par_val[i] = $urandom;
    base = done_cnt;
    ns0 = nonseq_cnt;
    push_seq(1, 32'h0F0F_F0F0, NP, 1);
    run_start(1, 32'h0F0F_F0F0);
    wait_done(cyc);
    rnd_mode = 0;
    end_seq("D", base, 1'b0);
    check("D_nonseq_count", 32'(nonseq_cnt - ns0), 32'(NP + 2));

    // E: ERROR on third parameter write aborts the sequence
    err_mode = 1; err_addr = BASE + 32'h108;
    for (int i = 0; i < NP; i++) par_val[i] = 32'hE000_0000 + 32'(i);
    base = done_cnt;
    ns0 = nonseq_cnt;
    push_seq(0, 32'hFFFF_0000, 3, 0);
    run_start(0, 32'hFFFF_0000);
    wait_done(cyc);
    check("E_err_at_done", 32'(err), 32'd1);
    repeat (10) @(negedge hclk);
    end_seq("E", base, 1'b1);
    check("E_nonseq_count", 32'(nonseq_cnt - ns0), 32'd3);
    err_mode = 0;

    // F: next start clears err and runs clean
    base = done_cnt;
    push_seq(0, 32'h5555_AAAA, NP, 1);
    run_start(0, 32'h5555_AAAA);
    wait_done(cyc);
    end_seq("F", base, 1'b0);

    // G: asynchronous reset during the second parameter data phase
    for (int i = 0; i < NP; i++) par_val[i] = 32'h6000_0000 + 32'(i * 3);
    push_seq(0, 32'h7777_0001, NP, 1);
    run_start(0, 32'h7777_0001);
    for (int i = 0; i < 500; i++) begin
      @(posedge hclk);
      #3;
      if (dp_act && dp_addr == BASE + 32'h104) break;
    end
    check("G_in_data_phase", 32'(dp_act && dp_addr == BASE + 32'h104), 32'd1);
    check("G_hwdata_pre_rst", hwdata, par_val[1]);
    hrst_n = 1'b0;
    #1;
    check_reset_vals("G_async");
    repeat (2) @(negedge hclk);
    exp_q.delete();
    hrst_n = 1'b1;
    repeat (3) @(negedge hclk);
    check("G_idle_after_rst", 32'(busy), 32'd0);
    base = done_cnt;
    push_seq(0, 32'h7777_0002, NP, 1);
    run_start(0, 32'h7777_0002);
    wait_done(cyc);
    end_seq("G", base, 1'b0);
    check("G_glb_ctrl", glb_ctrl, 32'h7777_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
